// File: rtl/replay_fifo_pkg.sv
// Shared defaults and helpers for the replay FIFO: pointer distance and replay-counter width.
package replay_fifo_pkg;

    localparam int unsigned RF_DATA_W_DEF     = 16;
    localparam int unsigned RF_DEPTH_DEF      = 8;
    localparam int unsigned RF_MAX_REPLAY_DEF = 3;

    // Modulo distance between two wrap-bit pointers of ptr_w bits.
    function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (a - b) & mask;
    endfunction

    // Bits needed to hold a replay counter that saturates at max_v.
    function automatic int unsigned replay_cnt_w(input int unsigned max_v);
        int unsigned w;
        if (max_v < 32'd1) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_v + 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/replay_fifo_mem.sv
// Simple dual-port RAM for replay_fifo: synchronous write, registered read port
// whose output register is cleared by the synchronous active-low reset.
module replay_fifo_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read data, holds its value when no read is issued.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/replay_fifo.sv
// FIFO that keeps read entries until ACKed and can rewind reads with REPLAY.
// Optional sticky OVF/UDF error ports are enabled by defining REPLAY_FIFO_ERR_FLAGS_EN.
module replay_fifo
    import replay_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = RF_DATA_W_DEF,
    parameter int unsigned DEPTH      = RF_DEPTH_DEF,
    parameter int unsigned MAX_REPLAY = RF_MAX_REPLAY_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     EN,
    input  logic                     WR,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     RD,
    input  logic                     ACK,
    input  logic                     REPLAY,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     dataValid,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   PEND_CNT,
    output logic [$clog2(DEPTH):0]   UNACK_CNT,
`ifdef REPLAY_FIFO_ERR_FLAGS_EN
    output logic                     REPLAY_ERR,
    output logic                     OVF,
    output logic                     UDF
`else
    output logic                     REPLAY_ERR
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned RC_W   = replay_cnt_w(MAX_REPLAY);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_ack_ptr;
    logic [RC_W-1:0]  r_replay_cnt;
    logic             r_replay_err;
    logic             r_data_valid;

    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_ack_ptr_nxt;
    logic [RC_W-1:0]  w_rc_base;
    logic [RC_W-1:0]  w_replay_cnt_nxt;
    logic             w_replay_err_nxt;

    logic [PTR_W-1:0] w_pend;
    logic [PTR_W-1:0] w_unack;
    logic [PTR_W-1:0] w_used;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_ack_ok;
    logic             w_replay;

    // Occupancy is derived from the start-of-cycle pointers only.
    assign w_pend  = PTR_W'(ptr_dist(32'(r_wr_ptr), 32'(r_rd_ptr),  PTR_W));
    assign w_unack = PTR_W'(ptr_dist(32'(r_rd_ptr), 32'(r_ack_ptr), PTR_W));
    assign w_used  = PTR_W'(ptr_dist(32'(r_wr_ptr), 32'(r_ack_ptr), PTR_W));
    assign w_empty = (r_rd_ptr == r_wr_ptr);
    assign w_full  = (w_used == PTR_W'(DEPTH));

    // A replay takes precedence over a same-cycle read.
    assign w_wr_ok  = EN & WR  & ~w_full;
    assign w_ack_ok = EN & ACK & (w_unack != {PTR_W{1'b0}});
    assign w_replay = EN & REPLAY;
    assign w_rd_ok  = EN & RD  & ~w_empty & ~REPLAY;

    // Next pointer values; the rewind target includes a same-cycle ACK.
    always_comb begin
        w_wr_ptr_nxt  = r_wr_ptr;
        w_ack_ptr_nxt = r_ack_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        if (w_wr_ok) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1'b1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end
        if (w_ack_ok) begin
            w_ack_ptr_nxt = r_ack_ptr + PTR_W'(1'b1);
        end else begin
            w_ack_ptr_nxt = r_ack_ptr;
        end
        if (w_replay) begin
            w_rd_ptr_nxt = w_ack_ptr_nxt;
        end else if (w_rd_ok) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1'b1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
    end

    // Replay counter: ACK progress clears it first, then a replay counts or trips the error.
    always_comb begin
        w_rc_base        = r_replay_cnt;
        w_replay_cnt_nxt = r_replay_cnt;
        w_replay_err_nxt = r_replay_err;
        if (w_ack_ok) begin
            w_rc_base = {RC_W{1'b0}};
        end else begin
            w_rc_base = r_replay_cnt;
        end
        if (w_replay) begin
            if (w_rc_base == RC_W'(MAX_REPLAY)) begin
                w_replay_cnt_nxt = w_rc_base;
                w_replay_err_nxt = 1'b1;
            end else begin
                w_replay_cnt_nxt = w_rc_base + RC_W'(1'b1);
                w_replay_err_nxt = r_replay_err;
            end
        end else begin
            w_replay_cnt_nxt = w_rc_base;
            w_replay_err_nxt = r_replay_err;
        end
    end

    // Pointer, counter and flag state with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_ack_ptr    <= {PTR_W{1'b0}};
            r_replay_cnt <= {RC_W{1'b0}};
            r_replay_err <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_ack_ptr    <= w_ack_ptr_nxt;
            r_replay_cnt <= w_replay_cnt_nxt;
            r_replay_err <= w_replay_err_nxt;
            r_data_valid <= w_rd_ok;
        end
    end

    replay_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (Clk),
        .i_rst_n (Rst),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (dataIn),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (dataOut)
    );

`ifdef REPLAY_FIFO_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    // Sticky overflow/underflow flags, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (EN & WR & w_full);
            r_udf <= r_udf | (EN & ((RD & w_empty & ~REPLAY) |
                                    (ACK & (w_unack == {PTR_W{1'b0}}))));
        end
    end

    assign OVF = r_ovf;
    assign UDF = r_udf;
`endif

    assign dataValid  = r_data_valid;
    assign EMPTY      = w_empty;
    assign FULL       = w_full;
    assign PEND_CNT   = w_pend;
    assign UNACK_CNT  = w_unack;
    assign REPLAY_ERR = r_replay_err;

endmodule
